// File: rtl/tx_cfg_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : tx_cfg_sched_if
//  Description : Register-write request channel between the HDMI TX config
//                scheduler (master) and the I2C write engine (slave).
//  Revision    : 1.0  initial release
// ============================================================================
interface tx_cfg_sched_if;
  logic       wr_req;
  logic [7:0] wr_reg;
  logic [7:0] wr_data;
  logic       wr_done;
  logic       wr_nack;

  modport master (output wr_req, output wr_reg, output wr_data,
                  input  wr_done, input  wr_nack);
  modport slave  (input  wr_req, input  wr_reg, input  wr_data,
                  output wr_done, output wr_nack);
endinterface
`default_nettype wire

// File: rtl/tx_cfg_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tx_cfg_sched
//  Description : HDMI transmitter configuration scheduler. Plays an init
//                table after start-up / hot-plug, then issues volume and
//                aspect register writes on demand, with NACK retry and an
//                enforced idle gap after every transaction.
//  Revision    : 1.0  initial release
// ============================================================================
module tx_cfg_sched #(
  parameter int unsigned          INIT_LEN    = 16,
  parameter logic [INIT_LEN*16-1:0] INIT_TABLE = '0,
  parameter int unsigned          STARTUP_DLY = 1000000,
  parameter int unsigned          GAP_CYC     = 64,
  parameter logic [7:0]           VOL_REG     = 8'h0A,
  parameter logic [7:0]           ASP_REG     = 8'h56
) (
  input  wire logic          PCLK,
  input  wire logic          reset,
  input  wire logic          btn_volplus,
  input  wire logic          btn_volminus,
  input  wire logic          int_n,
  input  wire logic          aspect,
  tx_cfg_sched_if.master     wr,
  output logic [3:0]         volume,
  output logic               init_done,
  output logic               busy,
  output logic [7:0]         err_cnt
);

  localparam logic [31:0] c_STARTUP_LAST = 32'(STARTUP_DLY - 1);
  localparam logic [31:0] c_GAP_LAST     = 32'(GAP_CYC - 1);
  localparam logic [5:0]  c_LAST_IDX     = 6'(INIT_LEN - 1);

  typedef enum logic [2:0] {
    ST_STARTUP = 3'd0, ST_IDLE = 3'd1, ST_ISSUE = 3'd2, ST_WAIT = 3'd3, ST_GAP = 3'd4
  } state_t;
  typedef enum logic [1:0] {SRC_INIT = 2'd0, SRC_ASP = 2'd1, SRC_VOL = 2'd2} src_t;

  state_t      r_state, w_state_nxt;
  src_t        r_src, w_load_src;
  logic        w_load, w_sel_init, w_sel_asp, w_sel_vol;
  logic [5:0]  r_idx, w_load_idx;
  logic [15:0] w_load_data;
  logic [31:0] r_cnt;
  logic [1:0]  r_retry;
  logic        r_again;
  logic [7:0]  r_err_cnt;
  logic        r_wr_req;
  logic [7:0]  r_wr_reg, r_wr_data;
  logic        r_int_s1, r_int_s2, r_int_s3;
  logic        r_plus_d1, r_plus_d2, r_minus_d1, r_minus_d2;
  logic        w_hotplug, w_plus_edge, w_minus_edge, w_vol_up, w_vol_dn;
  logic [3:0]  r_volume;
  logic        r_init_pend, r_asp_pend, r_vol_pend, r_init_done, r_asp_last;
  logic        w_asp_busy, w_wr_ok, w_wr_nack, w_init_fin;

  assign w_hotplug    = r_int_s3 & ~r_int_s2;
  assign w_plus_edge  = r_plus_d1 & ~r_plus_d2;
  assign w_minus_edge = r_minus_d1 & ~r_minus_d2;
  assign w_vol_up     = w_plus_edge & ~w_minus_edge & (r_volume != 4'd15);
  assign w_vol_dn     = w_minus_edge & ~w_plus_edge & (r_volume != 4'd0);
  assign w_wr_ok      = (r_state == ST_WAIT) & wr.wr_done & ~wr.wr_nack;
  assign w_wr_nack    = (r_state == ST_WAIT) & wr.wr_done & wr.wr_nack;
  // An aspect write already in flight must not re-raise its own request
  assign w_asp_busy   = (r_src == SRC_ASP) &
                        ((r_state == ST_ISSUE) | (r_state == ST_WAIT) | (r_state == ST_GAP));
  // Last table entry left the gap with no hot-plug restart queued
  assign w_init_fin   = (r_state == ST_GAP) & (w_state_nxt == ST_IDLE) &
                        (r_src == SRC_INIT) & (r_idx == c_LAST_IDX) & ~r_init_pend;

  // State register
  always_ff @(posedge PCLK) begin
    if (reset) r_state <= ST_STARTUP;
    else       r_state <= w_state_nxt;
  end

  // Next-state decode, source selection and payload load strobes
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_load_src  = SRC_INIT;
    w_load_idx  = '0;
    w_sel_init  = 1'b0;
    w_sel_asp   = 1'b0;
    w_sel_vol   = 1'b0;
    case (r_state)
      ST_STARTUP: begin
        if (r_cnt == c_STARTUP_LAST) begin
          w_state_nxt = ST_ISSUE;
          w_load      = 1'b1;
        end
      end
      ST_IDLE: begin
        if (r_init_pend) begin
          w_sel_init = 1'b1;
          w_load     = 1'b1;
        end else if (r_asp_pend) begin
          w_sel_asp  = 1'b1;
          w_load     = 1'b1;
          w_load_src = SRC_ASP;
        end else if (r_vol_pend) begin
          w_sel_vol  = 1'b1;
          w_load     = 1'b1;
          w_load_src = SRC_VOL;
        end
        if (w_load) w_state_nxt = ST_ISSUE;
      end
      ST_ISSUE: w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (wr.wr_done) w_state_nxt = ST_GAP;
      end
      ST_GAP: begin
        if (r_cnt == c_GAP_LAST) begin
          if (r_again) begin
            w_state_nxt = ST_ISSUE;
          end else if ((r_src == SRC_INIT) && !r_init_pend && (r_idx != c_LAST_IDX)) begin
            w_state_nxt = ST_ISSUE;
            w_load      = 1'b1;
            w_load_idx  = r_idx + 6'd1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_STARTUP;
    endcase
  end

  // Payload for the write about to be loaded
  always_comb begin
    w_load_data = INIT_TABLE[{w_load_idx, 4'b0000} +: 16];
    if (w_load_src == SRC_ASP)      w_load_data = {ASP_REG, aspect ? 8'h28 : 8'h18};
    else if (w_load_src == SRC_VOL) w_load_data = {VOL_REG, 4'h0, r_volume};
  end

  // Start-up and gap cycle counter, cleared on every state change
  always_ff @(posedge PCLK) begin
    if (reset)                            r_cnt <= '0;
    else if (r_state != w_state_nxt)      r_cnt <= '0;
    else if ((r_state == ST_STARTUP) || (r_state == ST_GAP)) r_cnt <= r_cnt + 32'd1;
  end

  // Write request channel; request held from ISSUE until completion
  always_ff @(posedge PCLK) begin
    if (reset) begin
      r_wr_req  <= 1'b0;
      r_wr_reg  <= '0;
      r_wr_data <= '0;
      r_src     <= SRC_INIT;
      r_idx     <= '0;
    end else begin
      r_wr_req <= (w_state_nxt == ST_ISSUE) || (w_state_nxt == ST_WAIT);
      if (w_load) begin
        {r_wr_reg, r_wr_data} <= w_load_data;
        r_src                 <= w_load_src;
        r_idx                 <= w_load_idx;
      end
    end
  end

  // NACK retry tracking, abandoned-write counter and last written aspect
  always_ff @(posedge PCLK) begin
    if (reset) begin
      r_retry    <= '0;
      r_again    <= 1'b0;
      r_err_cnt  <= '0;
      r_asp_last <= aspect;
    end else if (w_wr_nack) begin
      if (r_retry == 2'd3) begin
        r_retry <= '0;
        r_again <= 1'b0;
        if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
      end else begin
        r_retry <= r_retry + 2'd1;
        r_again <= 1'b1;
      end
    end else if (w_wr_ok) begin
      r_retry <= '0;
      r_again <= 1'b0;
      if (r_src == SRC_ASP) r_asp_last <= (r_wr_data == 8'h28);
    end
  end

  // Input conditioning: hot-plug synchronizer and button edge registers
  always_ff @(posedge PCLK) begin
    if (reset) begin
      {r_int_s1, r_int_s2, r_int_s3} <= 3'b111;
      {r_plus_d1, r_plus_d2, r_minus_d1, r_minus_d2} <= 4'b0000;
    end else begin
      {r_int_s1, r_int_s2, r_int_s3} <= {int_n, r_int_s1, r_int_s2};
      {r_plus_d1, r_plus_d2}   <= {btn_volplus, r_plus_d1};
      {r_minus_d1, r_minus_d2} <= {btn_volminus, r_minus_d1};
    end
  end

  // Saturating volume and pending-request flags; new events win over clears
  always_ff @(posedge PCLK) begin
    if (reset) begin
      r_volume    <= 4'd8;
      r_vol_pend  <= 1'b0;
      r_asp_pend  <= 1'b0;
      r_init_pend <= 1'b0;
      r_init_done <= 1'b0;
    end else begin
      if (w_vol_up)      r_volume <= r_volume + 4'd1;
      else if (w_vol_dn) r_volume <= r_volume - 4'd1;
      if (w_vol_up || w_vol_dn) r_vol_pend <= 1'b1;
      else if (w_sel_vol)       r_vol_pend <= 1'b0;
      if (w_sel_asp) r_asp_pend <= 1'b0;
      else if (r_init_done && (aspect != r_asp_last) && !w_asp_busy) r_asp_pend <= 1'b1;
      if (w_hotplug) r_init_pend <= 1'b1;
      else if (w_sel_init || (r_state == ST_STARTUP && w_state_nxt == ST_ISSUE))
        r_init_pend <= 1'b0;
      if (w_hotplug)       r_init_done <= 1'b0;
      else if (w_init_fin) r_init_done <= 1'b1;
    end
  end

  assign wr.wr_req  = r_wr_req;
  assign wr.wr_reg  = r_wr_reg;
  assign wr.wr_data = r_wr_data;
  assign volume     = r_volume;
  assign init_done  = r_init_done;
  assign busy       = (r_state != ST_IDLE);
  assign err_cnt    = r_err_cnt;

endmodule
`default_nettype wire

// File: doc/tx_cfg_sched.md
TX_CFG_SCHED -- requirements
Module: tx_cfg_sched

Interface
REQ-001 Parameter INIT_LEN, default 16: number of entries in the init table (1..64).
REQ-002 Parameter INIT_TABLE, default all-zero, INIT_LEN*16 bits: entry i = {reg[15:8], data[7:0]} at bits [16i+15:16i].
REQ-003 Parameter STARTUP_DLY, default 1000000: cycles from reset release to the first init write.
REQ-004 Parameter GAP_CYC, default 64: idle cycles enforced after every completed transaction.
REQ-005 Parameter VOL_REG, default 8'h0A: TX register that receives the volume value.
REQ-006 Parameter ASP_REG, default 8'h56: TX register that receives the AVI aspect byte.
REQ-007 Port PCLK, in, 1: sole clock; all logic on its rising edge.
REQ-008 Port reset, in, 1: reset is synchronous and active-high.
REQ-009 Port btn_volplus / btn_volminus, in, 1 each: debounced button levels, 1 = pressed.
REQ-010 Port int_n, in, 1: HDMI TX interrupt (hot-plug), active-low, asynchronous.
REQ-011 Port aspect, in, 1: current aspect (1 = 16:9, 0 = 4:3), quasi-static.
REQ-012 Port wr_req, out, 1: register-write request to the I2C master.
REQ-013 Port wr_reg / wr_data, out, 8 each: address and data of the pending write.
REQ-014 Port wr_done, in, 1: one-cycle pulse from the I2C master when the write finishes.
REQ-015 Port wr_nack, in, 1: valid only with wr_done; 1 = slave NACKed.
REQ-016 Port volume, out, 4: current volume step.
REQ-017 Port init_done, out, 1: init table fully issued since last reset or hot-plug.
REQ-018 Port busy, out, 1: high in any state other than IDLE.
REQ-019 Port err_cnt, out, 8: count of writes abandoned after retries.

Function
REQ-020 int_n passes through a 2-flop synchronizer; a falling edge of the synchronized value is a hot-plug event.
REQ-021 Button rising edges are detected on registered copies of the inputs; plus and minus rising in the same cycle are both ignored.
REQ-022 Volume is saturating 0..15: plus at 15 or minus at 0 leaves volume unchanged and sets no pending flag; any other accepted edge updates volume the next cycle and sets vol_pend.
REQ-023 asp_pend is set whenever aspect differs from the last successfully written aspect value (asp_last) and init_done=1.
REQ-024 States: STARTUP, IDLE, ISSUE, WAIT, GAP.
REQ-025 STARTUP: counts STARTUP_DLY cycles, then moves to ISSUE with source INIT and index 0.
REQ-026 IDLE: selects by fixed priority init_pend > asp_pend > vol_pend; clears the selected flag, latches wr_reg/wr_data, and enters ISSUE the next cycle; with no flag set it remains in IDLE.
REQ-027 Source data: INIT -> table entry at index; ASP -> {ASP_REG, aspect ? 8'h28 : 8'h18}; VOL -> {VOL_REG, 4'h0, volume sampled at selection}.
REQ-028 ISSUE asserts wr_req for one cycle, then enters WAIT; wr_req, wr_reg and wr_data hold stable from ISSUE until the cycle wr_done is sampled.
REQ-029 WAIT: on wr_done with wr_nack=0, wr_req drops the next cycle and the FSM enters GAP; for ASP, asp_last takes the written value.
REQ-030 NACK: up to 3 retries of the same write, each via GAP then ISSUE; a 4th NACK abandons the write and err_cnt increments, saturating at 255.
REQ-031 GAP: counts GAP_CYC cycles, then goes to ISSUE if INIT is active and index < INIT_LEN-1 (index+1), else to IDLE; init_done is set on leaving GAP after the last init entry.
REQ-032 A hot-plug event sets init_pend and clears init_done; an in-flight transaction completes normally; the new init restarts at index 0.
REQ-033 A hot-plug during an active init sequence abandons the remaining entries after the current transaction; the sequence restarts at 0.
REQ-034 Events arriving while busy only set pending flags; repeated volume edges coalesce into a single write of the latest volume.

Reset
REQ-035 On reset=1 at a clock edge: state=STARTUP, counters=0, wr_req=0, wr_reg=0, wr_data=0, volume=8, init_done=0, busy=1, err_cnt=0, all pending flags=0, asp_last=aspect, synchronizer flops=1.
REQ-036 Reset asserted mid-transaction drops wr_req the next cycle with no completion wait.

Verification
REQ-037 INIT_LEN=3, STARTUP_DLY=10, GAP_CYC=4, master acks 5 cycles after each req -> three writes in table order; init_done rises after the 3rd GAP.
REQ-038 After init, 3 plus edges during one transaction -> exactly one write {0x0A, 0x0B}; volume=11.
REQ-039 Volume at 15, plus edge -> no write; plus and minus together -> no change.
REQ-040 Slave NACKs a write 4 times -> 4 attempts with GAP between them; err_cnt=1; the sequence continues with the next entry.
REQ-041 aspect toggles 0->1 while a volume press is pending -> ASP write {0x56, 0x28} issued before the VOL write.
REQ-042 int_n pulse low during init entry 1 -> entry 1 completes, then the writes restart from entry 0; init_done stays 0 until the restarted sequence finishes.
